// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl: fetch sequencer choosing the next-PC mux source, with
// mispredict recovery bubbles, fetch stalls and register-jump base waits.
module fetch_seq_ctrl #(
   parameter int RECOV_CYC = 2,
   parameter int JWAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stall_fetch,
   input  logic       has_mispredict,
   input  logic       jump_for_pcsel,
   input  logic       jump_is_reg,
   input  logic       jump_base_rdy_from_rf,
   input  logic [1:0] pred_to_pcsel,
   input  logic       pcsel_from_bhndlr,
   output logic [2:0] PC_select,
   output logic       fetch_valid,
   output logic       flush_fetch,
   output logic       jwait_timeout,
   output logic [2:0] state_out
);
   typedef enum logic [2:0] {BOOT = 3'd0, RUN = 3'd1, STALL = 3'd2, JWAIT = 3'd3, RECOV = 3'd4} state_t;
   localparam logic [3:0] RLOAD = 4'(RECOV_CYC - 1);
   localparam logic [4:0] JMAX = 5'(JWAIT_MAX);
   state_t state, state_n;
   logic [2:0] pc_n;
   logic       fv_n, flush_n, jto_n;
   logic [3:0] rcnt, rcnt_n;
   logic [4:0] jcnt, jcnt_n;
   assign state_out = state;
   always_comb begin
      state_n = state;
      pc_n    = 3'd7;
      fv_n    = 1'b0;
      flush_n = 1'b0;
      jto_n   = jwait_timeout;
      rcnt_n  = rcnt;
      jcnt_n  = jcnt;
      if (state == BOOT) begin
         state_n = RUN;
         pc_n    = 3'd0;
         fv_n    = 1'b1;
      end else if (has_mispredict) begin
         state_n = RECOV;
         pc_n    = 3'd4;
         flush_n = 1'b1;
         rcnt_n  = RLOAD;
         jcnt_n  = 5'd0;
      end else if (state == RECOV) begin
         // bubble cycles: the recovery fetch is not presented until the count drains
         pc_n    = 3'd0;
         rcnt_n  = (rcnt != 4'd0) ? rcnt - 4'd1 : 4'd0;
         state_n = (rcnt == 4'd0) ? RUN : RECOV;
      end else if (stall_fetch) begin
         state_n = (state == JWAIT) ? JWAIT : STALL;
      end else if (state == JWAIT) begin
         state_n = jump_base_rdy_from_rf ? RUN : JWAIT;
         pc_n    = jump_base_rdy_from_rf ? 3'd3 : 3'd7;
         fv_n    = jump_base_rdy_from_rf;
         jcnt_n  = jump_base_rdy_from_rf ? 5'd0 : (jcnt >= JMAX) ? JMAX : jcnt + 5'd1;
         jto_n   = jwait_timeout | (!jump_base_rdy_from_rf && jcnt >= JMAX - 5'd1);
      end else if (jump_for_pcsel && jump_is_reg && !jump_base_rdy_from_rf) begin
         state_n = JWAIT;
         jcnt_n  = 5'd0;
      end else begin
         state_n = RUN;
         fv_n    = 1'b1;
         pc_n    = jump_for_pcsel    ? 3'd3 :
                   pred_to_pcsel[0]  ? 3'd1 :
                   pred_to_pcsel[1]  ? 3'd2 :
                   pcsel_from_bhndlr ? 3'd5 : 3'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= BOOT;
         PC_select     <= 3'd7;
         fetch_valid   <= 1'b0;
         flush_fetch   <= 1'b0;
         jwait_timeout <= 1'b0;
         rcnt          <= 4'd0;
         jcnt          <= 5'd0;
      end else begin
         state         <= state_n;
         PC_select     <= pc_n;
         fetch_valid   <= fv_n;
         flush_fetch   <= flush_n;
         jwait_timeout <= jto_n;
         rcnt          <= rcnt_n;
         jcnt          <= jcnt_n;
      end
   end
endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb_fetch_seq_ctrl: directed bench for fetch_seq_ctrl with hand-computed expectations.
module tb_fetch_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst, stall_fetch, has_mispredict, jump_for_pcsel, jump_is_reg, jump_base_rdy_from_rf, pcsel_from_bhndlr;
   logic [1:0] pred_to_pcsel;
   logic [2:0] PC_select, state_out;
   logic       fetch_valid, flush_fetch, jwait_timeout;
   int         checks = 0;
   int         errors = 0;

   fetch_seq_ctrl dut (
      .clk(clk), .rst(rst), .stall_fetch(stall_fetch), .has_mispredict(has_mispredict),
      .jump_for_pcsel(jump_for_pcsel), .jump_is_reg(jump_is_reg),
      .jump_base_rdy_from_rf(jump_base_rdy_from_rf), .pred_to_pcsel(pred_to_pcsel),
      .pcsel_from_bhndlr(pcsel_from_bhndlr), .PC_select(PC_select), .fetch_valid(fetch_valid),
      .flush_fetch(flush_fetch), .jwait_timeout(jwait_timeout), .state_out(state_out)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      {stall_fetch, has_mispredict, jump_for_pcsel, jump_is_reg, jump_base_rdy_from_rf, pcsel_from_bhndlr} = '0;
      pred_to_pcsel = 2'b00;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      has_mispredict = 1'b1;
      tick(3);
      chk("rst_state", 8'(state_out), 8'd0);
      chk("rst_pc", 8'(PC_select), 8'd7);
      chk("rst_fv", 8'(fetch_valid), 8'd0);
      chk("rst_flush_vs_mp", 8'(flush_fetch), 8'd0);
      chk("rst_jto", 8'(jwait_timeout), 8'd0);
      has_mispredict = 1'b0;
      rst = 1'b0;
      tick();
      chk("boot_exit_state", 8'(state_out), 8'd1);
      chk("run_pc", 8'(PC_select), 8'd0);
      chk("run_fv", 8'(fetch_valid), 8'd1);
      tick();
      chk("run2_fv", 8'(fetch_valid), 8'd1);
      // mispredict with RECOV_CYC=2
      has_mispredict = 1'b1;
      tick();
      chk("mp_pc", 8'(PC_select), 8'd4);
      chk("mp_flush", 8'(flush_fetch), 8'd1);
      chk("mp_fv", 8'(fetch_valid), 8'd0);
      chk("mp_state", 8'(state_out), 8'd4);
      has_mispredict = 1'b0;
      tick();
      chk("recov1_pc", 8'(PC_select), 8'd0);
      chk("recov1_fv", 8'(fetch_valid), 8'd0);
      chk("recov1_flush", 8'(flush_fetch), 8'd0);
      tick();
      chk("recov2_fv", 8'(fetch_valid), 8'd0);
      chk("recov2_state", 8'(state_out), 8'd1);
      tick();
      chk("recov_done_fv", 8'(fetch_valid), 8'd1);
      // register jump, base ready after 4 cycles
      jump_for_pcsel = 1'b1;
      jump_is_reg = 1'b1;
      tick();
      chk("jw_enter_pc", 8'(PC_select), 8'd7);
      chk("jw_enter_state", 8'(state_out), 8'd3);
      chk("jw_enter_fv", 8'(fetch_valid), 8'd0);
      tick(3);
      chk("jw_wait_pc", 8'(PC_select), 8'd7);
      jump_base_rdy_from_rf = 1'b1;
      tick();
      chk("jw_done_pc", 8'(PC_select), 8'd3);
      chk("jw_done_fv", 8'(fetch_valid), 8'd1);
      chk("jw_done_state", 8'(state_out), 8'd1);
      chk("jw_done_jto", 8'(jwait_timeout), 8'd0);
      idle();
      tick();
      chk("after_jump_pc", 8'(PC_select), 8'd0);
      // timeout with a stall freezing the counter
      jump_for_pcsel = 1'b1;
      jump_is_reg = 1'b1;
      tick();
      idle();
      tick(14);
      chk("to_pre_jto", 8'(jwait_timeout), 8'd0);
      stall_fetch = 1'b1;
      tick(3);
      chk("to_stall_jto", 8'(jwait_timeout), 8'd0);
      chk("to_stall_state", 8'(state_out), 8'd3);
      stall_fetch = 1'b0;
      tick();
      chk("to_set_jto", 8'(jwait_timeout), 8'd1);
      chk("to_set_pc", 8'(PC_select), 8'd7);
      tick(2);
      chk("to_sticky", 8'(jwait_timeout), 8'd1);
      chk("to_stay_state", 8'(state_out), 8'd3);
      has_mispredict = 1'b1;
      tick();
      chk("to_mp_pc", 8'(PC_select), 8'd4);
      chk("to_mp_state", 8'(state_out), 8'd4);
      chk("to_mp_jto", 8'(jwait_timeout), 8'd1);
      has_mispredict = 1'b0;
      tick(4);
      chk("to_recov_fv", 8'(fetch_valid), 8'd1);
      chk("to_recov_jto", 8'(jwait_timeout), 8'd1);
      // priority
      pred_to_pcsel = 2'b11;
      stall_fetch = 1'b1;
      has_mispredict = 1'b1;
      tick();
      chk("prio_mp_pc", 8'(PC_select), 8'd4);
      idle();
      tick(4);
      pred_to_pcsel = 2'b11;
      tick();
      chk("br_both_pc", 8'(PC_select), 8'd1);
      pred_to_pcsel = 2'b10;
      tick();
      chk("br1_pc", 8'(PC_select), 8'd2);
      pred_to_pcsel = 2'b00;
      pcsel_from_bhndlr = 1'b1;
      tick();
      chk("bh_pc", 8'(PC_select), 8'd5);
      pred_to_pcsel = 2'b01;
      tick();
      chk("br0_over_bh_pc", 8'(PC_select), 8'd1);
      jump_for_pcsel = 1'b1;
      pred_to_pcsel = 2'b11;
      tick();
      chk("imm_jump_pc", 8'(PC_select), 8'd3);
      jump_is_reg = 1'b1;
      jump_base_rdy_from_rf = 1'b1;
      tick();
      chk("reg_rdy_pc", 8'(PC_select), 8'd3);
      chk("reg_rdy_state", 8'(state_out), 8'd1);
      idle();
      stall_fetch = 1'b1;
      tick();
      chk("stall_pc", 8'(PC_select), 8'd7);
      chk("stall_state", 8'(state_out), 8'd2);
      chk("stall_fv", 8'(fetch_valid), 8'd0);
      pred_to_pcsel = 2'b01;
      tick();
      chk("stall_hold_pc", 8'(PC_select), 8'd7);
      stall_fetch = 1'b0;
      pred_to_pcsel = 2'b10;
      tick();
      chk("unstall_pc", 8'(PC_select), 8'd2);
      chk("unstall_state", 8'(state_out), 8'd1);
      chk("unstall_fv", 8'(fetch_valid), 8'd1);
      // reset mid-RECOV (recov_cnt=1), timeout flag still set
      idle();
      has_mispredict = 1'b1;
      tick();
      has_mispredict = 1'b0;
      rst = 1'b1;
      tick();
      chk("rst_recov_state", 8'(state_out), 8'd0);
      chk("rst_recov_flush", 8'(flush_fetch), 8'd0);
      chk("rst_recov_jto", 8'(jwait_timeout), 8'd0);
      chk("rst_recov_pc", 8'(PC_select), 8'd7);
      rst = 1'b0;
      tick();
      chk("rel_recov_pc", 8'(PC_select), 8'd0);
      chk("rel_recov_fv", 8'(fetch_valid), 8'd1);
      // reset mid-JWAIT
      jump_for_pcsel = 1'b1;
      jump_is_reg = 1'b1;
      tick();
      idle();
      rst = 1'b1;
      tick();
      chk("rst_jw_state", 8'(state_out), 8'd0);
      rst = 1'b0;
      tick();
      chk("rel_jw_state", 8'(state_out), 8'd1);
      chk("rel_jw_fv", 8'(fetch_valid), 8'd1);
      tick(16);
      chk("rel_jw_jto", 8'(jwait_timeout), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
